ship_controller: RTL and testbench
==================================

SHIP_CONTROLLER -- requirements
Module: ship_controller

Interface
REQ-001 Parameter LIVES_INIT, default 3: lives loaded on reset and on game start (range 1..7).
REQ-002 Parameter FIRE_COOLDOWN, default 16: frame ticks after a shot before the next shot is allowed.
REQ-003 Parameter EXPLODE_FRAMES, default 32: frame ticks spent in EXPLODING.
REQ-004 Parameter RESPAWN_FRAMES, default 64: frame ticks spent in RESPAWN.
REQ-005 clk  in  1  single system clock; all logic on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 v_sync  in  1  raw vertical sync level, synchronous to clk.
REQ-008 btn_left, btn_right, btn_fire, btn_start  in  1 each  player button levels.
REQ-009 bullet_active  in  1  player bullet currently in flight.
REQ-010 ship_hit  in  1  collision of the ship with an enemy projectile, sampled every cycle.
REQ-011 move_left, move_right  out  1 each  gated movement requests to the ship sprite block.
REQ-012 fire  out  1  one-cycle shot request to the bullet block.
REQ-013 respawn  out  1  one-cycle pulse telling the ship block to recentre.
REQ-014 ship_visible  out  1  ship drawn this frame.
REQ-015 exploding  out  1  explosion animation active; explode_phase out 2 = animation frame index.
REQ-016 lives  out  3  remaining lives; game_over  out  1  state is GAME_OVER.

Function
REQ-017 frame_tick: one-cycle internal pulse in the cycle after a registered v_sync 0->1 transition is detected; level high or falling edge produce no tick.
REQ-018 FSM states: WAIT_START, ALIVE, EXPLODING, RESPAWN, GAME_OVER.
REQ-019 WAIT_START or GAME_OVER + btn_start high -> ALIVE next cycle; lives := LIVES_INIT, cooldown := 0, respawn pulses that cycle.
REQ-020 move_left = ALIVE && btn_left && !btn_right; move_right symmetric; both buttons pressed -> both 0; combinational from registered state.
REQ-021 fire pulses for exactly one cycle on a frame_tick when ALIVE && btn_fire && !bullet_active && cooldown==0 && !ship_hit; same cycle cooldown := FIRE_COOLDOWN.
REQ-022 cooldown: 5-bit counter, decrements by 1 per frame_tick, saturates at 0; holding btn_fire yields one shot per FIRE_COOLDOWN+1 ticks at most.
REQ-023 ALIVE + ship_hit (any cycle) -> EXPLODING next cycle; lives decrements by 1 (never below 0); frame counter := 0.
REQ-024 ship_hit and a fire condition in the same cycle: hit wins, no fire pulse.
REQ-025 ship_hit outside ALIVE ignored (invulnerable during EXPLODING/RESPAWN).
REQ-026 EXPLODING: frame counter increments per frame_tick; explode_phase = counter[4:3]; after EXPLODE_FRAMES ticks -> GAME_OVER if lives==0 else RESPAWN, counter := 0.
REQ-027 RESPAWN: ship_visible=0; after RESPAWN_FRAMES ticks -> ALIVE, respawn pulses one cycle, cooldown := 0.
REQ-028 ship_visible = ALIVE || EXPLODING; exploding = EXPLODING.
REQ-029 frame counter is 7 bits; parameters above 127 are illegal.
REQ-030 btn_start while ALIVE, EXPLODING or RESPAWN has no effect.

Reset
REQ-031 rst synchronous, active-high, dominates all inputs; asserting it mid-operation (any state) returns to reset values next edge.
REQ-032 Reset values: state WAIT_START, lives LIVES_INIT, cooldown 0, frame counter 0, v_sync history 0, all outputs 0 except lives.

Structure
REQ-033 Shared package chip_pkg holds the ship_state_t enum and default constants for LIVES_INIT, FIRE_COOLDOWN, EXPLODE_FRAMES, RESPAWN_FRAMES.
REQ-034 One sub-module vsync_tick (registered rising-edge detector producing frame_tick); all other logic in ship_controller.

Verification
REQ-035 Reset, btn_start 1 cycle -> ALIVE, lives=3, respawn single pulse, move_left follows btn_left; btn_left+btn_right -> both moves 0.
REQ-036 Hold btn_fire 40 frames, bullet_active=0 -> exactly 3 fire pulses at ticks 0, 17, 34, each one cycle wide; bullet_active=1 -> none.
REQ-037 ship_hit in ALIVE -> lives 3->2, EXPLODING 32 ticks (phase 0..3), RESPAWN 64 ticks with ship_visible=0, then ALIVE with respawn pulse; ship_hit during EXPLODING ignored.
REQ-038 Three hits -> lives=0, after explosion game_over=1; btn_start -> ALIVE with lives=3.
REQ-039 ship_hit and fire condition same cycle -> no fire, EXPLODING entered.
REQ-040 rst asserted mid-RESPAWN -> WAIT_START, lives=3, all outputs 0 on next edge; v_sync held high 1000 cycles -> only one frame_tick.

Source files
------------

// File: rtl/chip_pkg.sv
// Shared ship-controller types and default tuning constants.
// Parameter defaults live here so every instantiation agrees on them.
package chip_pkg;

    typedef enum logic [2:0] {
        StWaitStart,
        StAlive,
        StExploding,
        StRespawn,
        StGameOver
    } ship_state_t;

    localparam int unsigned LivesInitDefault     = 3;
    localparam int unsigned FireCooldownDefault  = 16;
    localparam int unsigned ExplodeFramesDefault = 32;
    localparam int unsigned RespawnFramesDefault = 64;

    localparam int unsigned LivesWidth    = 3;
    localparam int unsigned CooldownWidth = 5;
    localparam int unsigned FrameCntWidth = 7;

    // Lives never wrap below zero.
    function automatic logic [LivesWidth-1:0] lives_after_hit(logic [LivesWidth-1:0] cur);
        return (cur == '0) ? '0 : cur - 3'd1;
    endfunction

endpackage

// File: rtl/vsync_tick.sv
// Registered rising-edge detector on the raw v_sync level.
// frame_tick is a single-cycle pulse, one cycle after the registered edge is seen.
module vsync_tick (
    input  logic clk,
    input  logic rst,
    input  logic v_sync,
    output logic frame_tick
);

    logic vs_q;
    logic vs_prev_q;
    logic tick_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            vs_q      <= 1'b0;
            vs_prev_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            vs_q      <= v_sync;
            vs_prev_q <= vs_q;
            tick_q    <= vs_q & ~vs_prev_q;
        end
    end

    assign frame_tick = tick_q;

endmodule

// File: rtl/ship_controller.sv
// Player ship controller: game-state FSM, shot rate limiting, lives and
// explosion/respawn sequencing, all paced by the frame tick.
module ship_controller
    import chip_pkg::*;
#(
    parameter int unsigned LIVES_INIT     = LivesInitDefault,
    parameter int unsigned FIRE_COOLDOWN  = FireCooldownDefault,
    parameter int unsigned EXPLODE_FRAMES = ExplodeFramesDefault,
    parameter int unsigned RESPAWN_FRAMES = RespawnFramesDefault
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       v_sync,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_fire,
    input  logic       btn_start,
    input  logic       bullet_active,
    input  logic       ship_hit,
    output logic       move_left,
    output logic       move_right,
    output logic       fire,
    output logic       respawn,
    output logic       ship_visible,
    output logic       exploding,
    output logic [1:0] explode_phase,
    output logic [2:0] lives,
    output logic       game_over
);

    localparam logic [LivesWidth-1:0]    LivesInit    = LivesWidth'(LIVES_INIT);
    localparam logic [CooldownWidth-1:0] CooldownLoad = CooldownWidth'(FIRE_COOLDOWN);
    // Counter holds ticks already spent, so the last tick is seen at N-1.
    localparam logic [FrameCntWidth-1:0] ExplodeLast  = FrameCntWidth'(EXPLODE_FRAMES - 1);
    localparam logic [FrameCntWidth-1:0] RespawnLast  = FrameCntWidth'(RESPAWN_FRAMES - 1);

    ship_state_t              state_q, state_d;
    logic [LivesWidth-1:0]    lives_q, lives_d;
    logic [CooldownWidth-1:0] cooldown_q, cooldown_d;
    logic [FrameCntWidth-1:0] frame_cnt_q, frame_cnt_d;

    logic frame_tick;
    logic fire_ok;
    logic start_game;
    logic respawn_done;

    vsync_tick u_vsync_tick (
        .clk        (clk),
        .rst        (rst),
        .v_sync     (v_sync),
        .frame_tick (frame_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StWaitStart;
            lives_q     <= LivesInit;
            cooldown_q  <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            lives_q     <= lives_d;
            cooldown_q  <= cooldown_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        lives_d      = lives_q;
        cooldown_d   = cooldown_q;
        frame_cnt_d  = frame_cnt_q;
        start_game   = 1'b0;
        respawn_done = 1'b0;

        // A hit in the same cycle suppresses the shot.
        fire_ok = frame_tick && (state_q == StAlive) && btn_fire && !bullet_active &&
                  (cooldown_q == '0) && !ship_hit;

        if (fire_ok) begin
            cooldown_d = CooldownLoad;
        end else if (frame_tick && (cooldown_q != '0)) begin
            cooldown_d = cooldown_q - 5'd1;
        end

        unique case (state_q)
            StWaitStart, StGameOver: begin
                if (btn_start) begin
                    start_game  = 1'b1;
                    state_d     = StAlive;
                    lives_d     = LivesInit;
                    cooldown_d  = '0;
                    frame_cnt_d = '0;
                end
            end
            StAlive: begin
                if (ship_hit) begin
                    state_d     = StExploding;
                    lives_d     = lives_after_hit(lives_q);
                    frame_cnt_d = '0;
                end
            end
            StExploding: begin
                if (frame_tick) begin
                    if (frame_cnt_q == ExplodeLast) begin
                        state_d     = (lives_q == '0) ? StGameOver : StRespawn;
                        frame_cnt_d = '0;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 7'd1;
                    end
                end
            end
            StRespawn: begin
                if (frame_tick) begin
                    if (frame_cnt_q == RespawnLast) begin
                        respawn_done = 1'b1;
                        state_d      = StAlive;
                        cooldown_d   = '0;
                        frame_cnt_d  = '0;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 7'd1;
                    end
                end
            end
            default: begin
                state_d = StWaitStart;
            end
        endcase
    end

    // Pulses are gated by rst so a reset cycle never leaks a request downstream.
    assign fire          = fire_ok && !rst;
    assign respawn       = (start_game || respawn_done) && !rst;
    assign move_left     = (state_q == StAlive) && btn_left && !btn_right;
    assign move_right    = (state_q == StAlive) && btn_right && !btn_left;
    assign ship_visible  = (state_q == StAlive) || (state_q == StExploding);
    assign exploding     = (state_q == StExploding);
    assign explode_phase = exploding ? frame_cnt_q[4:3] : 2'b00;
    assign lives         = lives_q;
    assign game_over     = (state_q == StGameOver);

endmodule

// File: tb/tb_ship_controller.sv
// Self-checking bench for ship_controller: vector table, directed sequences
// and a randomized run against a cycle-level behavioural model.
module tb_ship_controller;

    localparam int LI = 3;
    localparam int FC = 16;
    localparam int EF = 32;
    localparam int RF = 64;

    localparam int MWait  = 0;
    localparam int MAlive = 1;
    localparam int MExpl  = 2;
    localparam int MResp  = 3;
    localparam int MOver  = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       v_sync;
    logic       btn_left, btn_right, btn_fire, btn_start;
    logic       bullet_active, ship_hit;
    logic       move_left, move_right, fire, respawn, ship_visible, exploding;
    logic [1:0] explode_phase;
    logic [2:0] lives;
    logic       game_over;

    always #5 clk = ~clk;

    ship_controller #(
        .LIVES_INIT     (LI),
        .FIRE_COOLDOWN  (FC),
        .EXPLODE_FRAMES (EF),
        .RESPAWN_FRAMES (RF)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .v_sync        (v_sync),
        .btn_left      (btn_left),
        .btn_right     (btn_right),
        .btn_fire      (btn_fire),
        .btn_start     (btn_start),
        .bullet_active (bullet_active),
        .ship_hit      (ship_hit),
        .move_left     (move_left),
        .move_right    (move_right),
        .fire          (fire),
        .respawn       (respawn),
        .ship_visible  (ship_visible),
        .exploding     (exploding),
        .explode_phase (explode_phase),
        .lives         (lives),
        .game_over     (game_over)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: game mode, lives, shot cooldown, ticks spent in the
    // current timed mode, and the last three v_sync samples (hist[0] newest).
    int         m_mode, m_lives, m_cd, m_fc;
    logic [2:0] m_hist;
    int         cyc     = 0;
    int         vs_mode = 0;  // 0 low, 1 periodic, 2 held high, 3 random

    logic       s_ml, s_mr, s_fire, s_respawn, s_vis, s_expl, s_go, s_tick;
    logic [1:0] s_phase;
    logic [2:0] s_lives;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Tick seen in the cycle after a registered rising edge: v[t-2]=1, v[t-3]=0.
    function automatic logic model_tick();
        return m_hist[1] && !m_hist[2];
    endfunction

    function automatic logic model_fire();
        return !rst && model_tick() && m_mode == MAlive && btn_fire && !bullet_active &&
               m_cd == 0 && !ship_hit;
    endfunction

    function automatic logic [11:0] model_out();
        logic alive, ml, mr, rsp, vis, ex;
        logic [1:0] ph;
        alive = (m_mode == MAlive);
        ml    = alive && btn_left && !btn_right;
        mr    = alive && btn_right && !btn_left;
        rsp   = !rst && (((m_mode == MWait || m_mode == MOver) && btn_start) ||
                         (m_mode == MResp && model_tick() && m_fc == RF - 1));
        vis   = (m_mode == MAlive || m_mode == MExpl);
        ex    = (m_mode == MExpl);
        ph    = ex ? 2'((m_fc / 8) % 4) : 2'd0;
        return {ml, mr, model_fire(), rsp, vis, ex, ph, 3'(m_lives), (m_mode == MOver)};
    endfunction

    task automatic model_reset();
        m_mode  = MWait;
        m_lives = LI;
        m_cd    = 0;
        m_fc    = 0;
        m_hist  = 3'b000;
    endtask

    task automatic model_step();
        logic tick, shot;
        tick = model_tick();
        shot = model_fire();
        if (rst) begin
            model_reset();
            return;
        end
        m_hist = {m_hist[1:0], v_sync};
        if (shot) m_cd = FC;
        else if (tick && m_cd > 0) m_cd = m_cd - 1;
        case (m_mode)
            MWait, MOver: if (btn_start) begin
                m_mode = MAlive; m_lives = LI; m_cd = 0; m_fc = 0;
            end
            MAlive: if (ship_hit) begin
                m_mode = MExpl; m_lives = (m_lives > 0) ? m_lives - 1 : 0; m_fc = 0;
            end
            MExpl: if (tick) begin
                m_fc = m_fc + 1;
                if (m_fc == EF) begin
                    m_mode = (m_lives == 0) ? MOver : MResp; m_fc = 0;
                end
            end
            MResp: if (tick) begin
                m_fc = m_fc + 1;
                if (m_fc == RF) begin
                    m_mode = MAlive; m_fc = 0; m_cd = 0;
                end
            end
            default: m_mode = MWait;
        endcase
    endtask

    // One clock: drive v_sync, sample and compare at negedge, advance model at posedge.
    task automatic cycle();
        logic [11:0] act;
        case (vs_mode)
            0:       v_sync = 1'b0;
            1:       v_sync = ((cyc % 8) < 2);
            2:       v_sync = 1'b1;
            default: v_sync = ($urandom_range(0, 3) == 0);
        endcase
        @(negedge clk);
        s_ml = move_left; s_mr = move_right; s_fire = fire; s_respawn = respawn;
        s_vis = ship_visible; s_expl = exploding; s_phase = explode_phase;
        s_lives = lives; s_go = game_over; s_tick = model_tick();
        act = {move_left, move_right, fire, respawn, ship_visible, exploding,
               explode_phase, lives, game_over};
        check("model_outputs", 32'(act), 32'(model_out()));
        @(posedge clk);
        model_step();
        cyc++;
        #1;
    endtask

    task automatic hit_and_explode(input int exp_lives, input bit expect_over,
                                   input bit fire_clash);
        int n, ticks, lives_bad, vis_bad, rticks;
        logic [3:0] phases;
        bit got;
        if (fire_clash) begin
            n = 0;
            btn_fire = 1'b0;
            bullet_active = 1'b0;
            while (!model_tick() && n < 100) begin cycle(); n++; end
            check("clash_wait", 32'(n < 100), 32'd1);
            btn_fire = 1'b1;
        end
        ship_hit = 1'b1;
        cycle();
        if (fire_clash) check("clash_no_fire", 32'(s_fire), 32'd0);
        ship_hit = 1'b0;
        btn_fire = 1'b0;

        n = 0; ticks = 0; lives_bad = 0; phases = 4'b0;
        do begin
            ship_hit = (n == 40);
            cycle();
            ship_hit = 1'b0;
            n++;
            if (s_expl) begin
                if (s_tick) ticks++;
                phases[s_phase] = 1'b1;
                if (s_lives != 3'(exp_lives)) lives_bad++;
            end
        end while (s_expl && n < 1000);
        check("expl_timeout", 32'(n < 1000), 32'd1);
        check("expl_ticks", 32'(ticks), 32'(EF));
        check("expl_phases", 32'(phases), 32'hF);
        check("expl_lives", 32'(lives_bad), 32'd0);

        if (expect_over) begin
            check("game_over", 32'(s_go), 32'd1);
            check("over_lives", 32'(s_lives), 32'd0);
            return;
        end

        rticks = s_tick ? 1 : 0;
        vis_bad = s_vis ? 1 : 0;
        got = s_respawn;
        n = 0;
        while (!got && n < 2000) begin
            ship_hit = (n == 100);
            cycle();
            ship_hit = 1'b0;
            n++;
            if (s_tick) rticks++;
            if (s_vis) vis_bad++;
            got = s_respawn;
        end
        check("resp_seen", 32'(got), 32'd1);
        check("resp_ticks", 32'(rticks), 32'(RF));
        check("resp_hidden", 32'(vis_bad), 32'd0);
        cycle();
        check("resp_alive", 32'({s_vis, s_expl, s_respawn}), 32'b100);
        check("resp_lives", 32'(s_lives), 32'(exp_lives));
    endtask

    typedef struct {
        logic l, r, f;
        logic eml, emr;
    } mv_vec_t;

    initial begin
        mv_vec_t tbl[6];
        int n, tick_idx, fires, wide, prev_fire;
        int fire_at[$];

        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

        rst = 1'b1; v_sync = 1'b0;
        btn_left = 0; btn_right = 0; btn_fire = 0; btn_start = 0;
        bullet_active = 0; ship_hit = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();

        // Reset state, then start.
        cycle();
        check("reset_lives", 32'(s_lives), 32'd3);
        check("reset_outs", 32'({s_ml, s_mr, s_fire, s_respawn, s_vis, s_expl, s_phase, s_go}),
              32'd0);
        btn_start = 1'b1;
        cycle();
        check("start_respawn", 32'(s_respawn), 32'd1);
        btn_start = 1'b0;
        cycle();
        check("start_alive", 32'(s_vis), 32'd1);
        check("start_lives", 32'(s_lives), 32'd3);
        check("respawn_single", 32'(s_respawn), 32'd0);

        // Movement gating table (no frame ticks, so no shots).
        for (int i = 0; i < 6; i++) begin
            btn_left = tbl[i].l; btn_right = tbl[i].r; btn_fire = tbl[i].f;
            cycle();
            check("tbl_move", 32'({s_ml, s_mr}), 32'({tbl[i].eml, tbl[i].emr}));
            check("tbl_no_fire", 32'(s_fire), 32'd0);
        end
        btn_left = 0; btn_right = 0; btn_fire = 0;

        // Held fire over 40 frames.
        vs_mode = 1; btn_fire = 1'b1; bullet_active = 1'b0;
        tick_idx = 0; wide = 0; prev_fire = 0; n = 0;
        while (tick_idx < 40 && n < 1000) begin
            cycle(); n++;
            if (s_fire) fire_at.push_back(tick_idx);
            if (s_fire && prev_fire != 0) wide++;
            prev_fire = s_fire;
            if (s_tick) tick_idx++;
        end
        check("fire_timeout", 32'(n < 1000), 32'd1);
        check("fire_count", 32'(fire_at.size()), 32'd3);
        if (fire_at.size() == 3) begin
            check("fire_at0", 32'(fire_at[0]), 32'd0);
            check("fire_at1", 32'(fire_at[1]), 32'd17);
            check("fire_at2", 32'(fire_at[2]), 32'd34);
        end
        check("fire_width", 32'(wide), 32'd0);

        // Bullet already in flight blocks every shot.
        bullet_active = 1'b1; fires = 0; tick_idx = 0; n = 0;
        while (tick_idx < 20 && n < 1000) begin
            cycle(); n++;
            if (s_fire) fires++;
            if (s_tick) tick_idx++;
        end
        check("bullet_block", 32'(fires), 32'd0);
        bullet_active = 1'b0; btn_fire = 1'b0;

        // Three hits to game over, the second clashing with a shot.
        hit_and_explode(2, 1'b0, 1'b0);
        hit_and_explode(1, 1'b0, 1'b1);
        hit_and_explode(0, 1'b1, 1'b0);
        btn_start = 1'b1;
        cycle();
        check("restart_respawn", 32'(s_respawn), 32'd1);
        btn_start = 1'b0;
        cycle();
        check("restart_state", 32'({s_vis, s_go}), 32'b10);
        check("restart_lives", 32'(s_lives), 32'd3);

        // Reset in the middle of RESPAWN.
        ship_hit = 1'b1; cycle(); ship_hit = 1'b0;
        n = 0;
        do begin cycle(); n++; end while (s_expl && n < 1000);
        repeat (20) cycle();
        check("in_respawn", 32'({s_vis, s_expl, s_go}), 32'd0);
        rst = 1'b1; cycle(); rst = 1'b0;
        cycle();
        check("rst_lives", 32'(s_lives), 32'd3);
        check("rst_outs", 32'({s_ml, s_mr, s_fire, s_respawn, s_vis, s_expl, s_phase, s_go}),
              32'd0);

        // v_sync held high: a single tick, observed as a single shot.
        vs_mode = 0;
        repeat (10) cycle();
        btn_start = 1'b1; cycle(); btn_start = 1'b0;
        vs_mode = 2; btn_fire = 1'b1; fires = 0;
        repeat (1000) begin
            cycle();
            if (s_fire) fires++;
        end
        check("vsync_high_one_tick", 32'(fires), 32'd1);
        btn_fire = 1'b0;

        // Randomized run against the model.
        vs_mode = 3;
        repeat (5000) begin
            btn_left      = 1'($urandom_range(0, 1));
            btn_right     = 1'($urandom_range(0, 1));
            btn_fire      = 1'($urandom_range(0, 1));
            bullet_active = ($urandom_range(0, 3) == 0);
            ship_hit      = ($urandom_range(0, 99) == 0);
            btn_start     = ($urandom_range(0, 49) == 0);
            rst           = ($urandom_range(0, 999) == 0);
            cycle();
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
